// File: rtl/ttt_nxn.sv
// N x N tic-tac-toe engine with a K-in-a-row win rule.
// Each accepted move is followed by a four-cycle directional scan and then a one-cycle verdict.
module ttt_nxn #(
    parameter int N       = 3,
    parameter int K       = 3,
    parameter int COORD_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               restart,
    input  logic [COORD_W-1:0] data_in_x,
    input  logic [COORD_W-1:0] data_in_y,
    output logic [2*N*N-1:0]   board,
    output logic               player,
    output logic               winner,
    output logic               draw,
    output logic               stop_game,
    output logic               busy,
    output logic               move_ok,
    output logic               move_err
);

    localparam int CELLS = N * N;
    localparam int CNT_W = $clog2(CELLS + 1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DONE,
        OVER
    } state_t;

    state_t             state;
    logic [1:0]         dir;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic [CNT_W-1:0]   count;
    logic               win;

    logic [1:0]         code;
    logic               legal;
    int                 move_idx;
    int                 dx;
    int                 dy;
    int                 run;
    logic               go_fwd;
    logic               go_bwd;

    // Off-board coordinates read as empty, which ends a run at the edge.
    function automatic logic [1:0] cell_at(input logic [2*N*N-1:0] b, input int x, input int y);
        logic [1:0] c;
        c = 2'b00;
        if (x >= 0 && x < N && y >= 0 && y < N)
            c = b[2*(y*N+x) +: 2];
        return c;
    endfunction

    always_comb begin
        code     = player ? 2'b10 : 2'b01;
        move_idx = 2 * (int'(data_in_y) * N + int'(data_in_x));
        legal    = 1'b0;
        if (int'(data_in_x) < N && int'(data_in_y) < N)
            legal = (board[move_idx +: 2] == 2'b00);
    end

    // Run length through the latched cell along the current direction, both ways.
    always_comb begin
        dx = 1;
        dy = 0;
        case (dir)
            2'd0: begin
                dx = 1;
                dy = 0;
            end
            2'd1: begin
                dx = 0;
                dy = 1;
            end
            2'd2: begin
                dx = 1;
                dy = 1;
            end
            default: begin
                dx = 1;
                dy = -1;
            end
        endcase
        run    = 1;
        go_fwd = 1'b1;
        go_bwd = 1'b1;
        for (int i = 1; i < K; i++) begin
            if (go_fwd && cell_at(board, int'(cur_x) + i*dx, int'(cur_y) + i*dy) == code)
                run = run + 1;
            else
                go_fwd = 1'b0;
            if (go_bwd && cell_at(board, int'(cur_x) - i*dx, int'(cur_y) - i*dy) == code)
                run = run + 1;
            else
                go_bwd = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            board     <= '0;
            player    <= 1'b0;
            winner    <= 1'b0;
            draw      <= 1'b0;
            stop_game <= 1'b0;
            busy      <= 1'b0;
            move_ok   <= 1'b0;
            move_err  <= 1'b0;
            count     <= '0;
            dir       <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
            win       <= 1'b0;
        end else if (restart) begin
            state     <= IDLE;
            board     <= '0;
            player    <= 1'b0;
            winner    <= 1'b0;
            draw      <= 1'b0;
            stop_game <= 1'b0;
            busy      <= 1'b0;
            move_ok   <= 1'b0;
            move_err  <= 1'b0;
            count     <= '0;
            dir       <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
            win       <= 1'b0;
        end else begin
            move_ok  <= 1'b0;
            move_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        if (legal) begin
                            board[move_idx +: 2] <= code;
                            cur_x   <= data_in_x;
                            cur_y   <= data_in_y;
                            count   <= count + CNT_W'(1);
                            move_ok <= 1'b1;
                            busy    <= 1'b1;
                            dir     <= 2'd0;
                            win     <= 1'b0;
                            state   <= CHECK;
                        end else begin
                            move_err <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (enable)
                        move_err <= 1'b1;
                    if (run >= K)
                        win <= 1'b1;
                    dir <= dir + 2'd1;
                    if (dir == 2'd3)
                        state <= DONE;
                end
                DONE: begin
                    if (enable)
                        move_err <= 1'b1;
                    busy <= 1'b0;
                    if (win) begin
                        winner    <= player;
                        stop_game <= 1'b1;
                        state     <= OVER;
                    end else if (count == CNT_W'(CELLS)) begin
                        draw      <= 1'b1;
                        stop_game <= 1'b1;
                        state     <= OVER;
                    end else begin
                        player <= ~player;
                        state  <= IDLE;
                    end
                end
                default: begin
                    if (enable)
                        move_err <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ttt_nxn.sv
// Directed bench for ttt_nxn: three instances (3x3 K=3, 5x5 K=4, 5x5 K=5) driven from one script,
// with a small board model and a queue of expected accept/reject responses.
module tb_ttt_nxn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        restart;
    logic [2:0]  en;
    logic [2:0]  data_in_x;
    logic [2:0]  data_in_y;

    logic [17:0] board0;
    logic [49:0] board1;
    logic [49:0] board2;
    logic [2:0]  player_v, winner_v, draw_v, stop_v, busy_v, ok_v, err_v;

    ttt_nxn #(.N(3), .K(3), .COORD_W(3)) dut0 (
        .clk(clk), .reset(reset), .enable(en[0]), .restart(restart),
        .data_in_x(data_in_x), .data_in_y(data_in_y), .board(board0),
        .player(player_v[0]), .winner(winner_v[0]), .draw(draw_v[0]),
        .stop_game(stop_v[0]), .busy(busy_v[0]), .move_ok(ok_v[0]), .move_err(err_v[0])
    );

    ttt_nxn #(.N(5), .K(4), .COORD_W(3)) dut1 (
        .clk(clk), .reset(reset), .enable(en[1]), .restart(restart),
        .data_in_x(data_in_x), .data_in_y(data_in_y), .board(board1),
        .player(player_v[1]), .winner(winner_v[1]), .draw(draw_v[1]),
        .stop_game(stop_v[1]), .busy(busy_v[1]), .move_ok(ok_v[1]), .move_err(err_v[1])
    );

    ttt_nxn #(.N(5), .K(5), .COORD_W(3)) dut2 (
        .clk(clk), .reset(reset), .enable(en[2]), .restart(restart),
        .data_in_x(data_in_x), .data_in_y(data_in_y), .board(board2),
        .player(player_v[2]), .winner(winner_v[2]), .draw(draw_v[2]),
        .stop_game(stop_v[2]), .busy(busy_v[2]), .move_ok(ok_v[2]), .move_err(err_v[2])
    );

    int            sel;
    int            mn;
    int            mb [64];
    logic          mp;
    logic          mover;
    logic          mbusy;
    int            checks = 0;
    int            fails  = 0;
    logic [1:0]    exp_q [$];
    logic [127:0]  obs_board;

    always_comb begin
        obs_board = '0;
        case (sel)
            0:       obs_board = 128'(board0);
            1:       obs_board = 128'(board1);
            default: obs_board = 128'(board2);
        endcase
    end

    function automatic logic [127:0] model_board();
        logic [127:0] b;
        b = '0;
        for (int i = 0; i < mn*mn; i++)
            b[2*i +: 2] = 2'(mb[i]);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++)
            mb[i] = 0;
        mp    = 1'b0;
        mover = 1'b0;
        mbusy = 1'b0;
    endtask

    // One enable strobe; the expected {move_ok, move_err} comes from the model.
    task automatic strobe(input int x, input int y, input string tag);
        logic       legal;
        logic [1:0] e;
        legal = !mbusy && !mover && x < mn && y < mn;
        if (legal)
            legal = (mb[y*mn+x] == 0);
        exp_q.push_back(legal ? 2'b10 : 2'b01);
        data_in_x = 3'(x);
        data_in_y = 3'(y);
        en[sel]   = 1'b1;
        @(posedge clk);
        #1;
        en = '0;
        e  = exp_q.pop_front();
        chk(tag, {126'd0, ok_v[sel], err_v[sel]}, {126'd0, e});
        if (legal) begin
            mb[y*mn+x] = mp ? 2 : 1;
            mbusy      = 1'b1;
        end
    endtask

    task automatic move(input int x, input int y, input logic ends, input logic poke);
        int cyc;
        strobe(x, y, "move_resp");
        if (mbusy) begin
            cyc = busy_v[sel] ? 1 : 0;
            if (poke) begin
                strobe(2, 2, "enable_while_busy");
                if (busy_v[sel]) cyc++;
            end
            for (int i = 0; i < 20 && busy_v[sel]; i++) begin
                @(posedge clk);
                #1;
                if (busy_v[sel]) cyc++;
            end
            chk("busy_cycles", 128'(cyc), 128'd5);
            mbusy = 1'b0;
            if (ends) mover = 1'b1;
            else      mp    = ~mp;
            chk("player", {127'd0, player_v[sel]}, {127'd0, mp});
            chk("stop_game", {127'd0, stop_v[sel]}, {127'd0, mover});
        end
        chk("board", obs_board, model_board());
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        model_clear();
        chk("restart_board", obs_board, 128'd0);
        chk("restart_flags", {124'd0, player_v[sel], stop_v[sel], busy_v[sel], draw_v[sel]}, 128'd0);
    endtask

    task automatic start(input int s);
        sel = s;
        mn  = (s == 0) ? 3 : 5;
        do_restart();
    endtask

    initial begin
        reset     = 1'b1;
        restart   = 1'b0;
        en        = '0;
        data_in_x = '0;
        data_in_y = '0;
        sel       = 0;
        mn        = 3;
        model_clear();
        #12;
        chk("reset_state", {obs_board[17:0], player_v[0], winner_v[0], draw_v[0], stop_v[0],
                            busy_v[0], ok_v[0], err_v[0]}, 128'd0);
        reset = 1'b0;

        // Column x=0 win for player 0
        start(0);
        move(0, 0, 1'b0, 1'b0);
        move(1, 0, 1'b0, 1'b0);
        move(0, 1, 1'b0, 1'b0);
        move(1, 1, 1'b0, 1'b0);
        move(0, 2, 1'b1, 1'b0);
        chk("win_board", obs_board, 128'h01249);
        chk("win_winner", {127'd0, winner_v[0]}, 128'd0);
        chk("win_draw", {127'd0, draw_v[0]}, 128'd0);
        strobe(2, 2, "enable_when_over");
        chk("over_board", obs_board, 128'h01249);
        do_restart();

        // Full board, no line
        move(0, 0, 1'b0, 1'b0);
        move(1, 0, 1'b0, 1'b0);
        move(2, 0, 1'b0, 1'b0);
        move(1, 1, 1'b0, 1'b0);
        move(1, 2, 1'b0, 1'b0);
        move(2, 1, 1'b0, 1'b0);
        move(0, 1, 1'b0, 1'b0);
        move(0, 2, 1'b0, 1'b0);
        move(2, 2, 1'b1, 1'b0);
        chk("draw_flag", {127'd0, draw_v[0]}, 128'd1);
        chk("draw_player", {127'd0, player_v[0]}, 128'd0);

        // Player 1 wins on column x=1
        start(0);
        move(0, 0, 1'b0, 1'b0);
        move(1, 0, 1'b0, 1'b0);
        move(0, 1, 1'b0, 1'b0);
        move(1, 1, 1'b0, 1'b0);
        move(2, 2, 1'b0, 1'b0);
        move(1, 2, 1'b1, 1'b0);
        chk("p1_winner", {127'd0, winner_v[0]}, 128'd1);
        chk("p1_draw", {127'd0, draw_v[0]}, 128'd0);

        // Illegal moves: occupied cell and off-board column
        start(0);
        move(0, 0, 1'b0, 1'b0);
        strobe(0, 0, "occupied");
        strobe(3, 1, "off_board");
        chk("illegal_board", obs_board, model_board());
        chk("illegal_player", {127'd0, player_v[0]}, 128'd1);

        // Strobe during the scan
        start(0);
        move(0, 0, 1'b0, 1'b1);

        // 5x5 diagonal, K=4 wins, K=5 does not
        for (int s = 1; s <= 2; s++) begin
            start(s);
            move(1, 1, 1'b0, 1'b0);
            move(0, 0, 1'b0, 1'b0);
            move(2, 2, 1'b0, 1'b0);
            move(1, 0, 1'b0, 1'b0);
            move(3, 3, 1'b0, 1'b0);
            move(2, 0, 1'b0, 1'b0);
            move(4, 4, (s == 1), 1'b0);
            chk("diag_winner", {127'd0, winner_v[sel]}, 128'd0);
            chk("diag_draw", {127'd0, draw_v[sel]}, 128'd0);
        end

        // Asynchronous reset in the middle of the scan
        start(0);
        strobe(0, 0, "pre_reset_move");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("busy_before_reset", {127'd0, busy_v[0]}, 128'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", {obs_board[17:0], player_v[0], winner_v[0], draw_v[0], stop_v[0],
                            busy_v[0], ok_v[0], err_v[0]}, 128'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        move(0, 0, 1'b0, 1'b0);
        chk("post_reset_board", obs_board, 128'h1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/ttt_nxn.md
Name: ttt_nxn

Overview:
Parametrised successor of the 3x3 tic-tac-toe engine: an N x N board where K in a row wins.
- Accepts one move per enable strobe and rejects illegal moves with an error pulse.
- Runs a fixed-latency 4-direction win scan around the placed cell, then detects win or draw.
- Sits between the input decoder (x/y coordinates) and the board display logic; exports the packed board.

Parameters:
N, 3, board side length (3..8)
K, 3, run length needed to win (2..N)
COORD_W, 3, coordinate width; 2**COORD_W >= N

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
enable  input  1  move strobe, sampled on rising edge
restart  input  1  synchronous clear to post-reset state; priority over enable
data_in_x  input  COORD_W  column of move
data_in_y  input  COORD_W  row of move
board  output  2*N*N  packed board; cell (x,y) at bits [2*(y*N+x)+1 : 2*(y*N+x)]; 00 empty, 01 player 0, 10 player 1
player  output  1  side to move
winner  output  1  id of winning player; valid when stop_game=1 and draw=0
draw  output  1  board full with no win
stop_game  output  1  game over (win or draw)
busy  output  1  win scan in progress
move_ok  output  1  one-cycle pulse: move accepted
move_err  output  1  one-cycle pulse: move rejected

Behaviour:
- Reset (async, active-high): board=0, player=0, winner=0, draw=0, stop_game=0, busy=0, move_ok=0, move_err=0, move count=0, FSM=IDLE. Reset asserted mid-scan aborts the scan immediately.
- restart=1 on an edge: same end state as reset, in any state; enable is ignored that cycle.
- FSM states: IDLE, CHECK (dir 0..3), DONE, OVER.
- IDLE, enable=1 at edge E0:
  - Legal move (x<N, y<N, cell 00): write cell with the player code (player 0 -> 01, player 1 -> 10), latch x/y, count+1, move_ok=1 for one cycle, go to CHECK with dir=0, busy=1.
  - Illegal move: move_err=1 for one cycle; board, player and count unchanged; stay IDLE.
- CHECK, one direction per cycle, at edges E1..E4:
  - dir 0 = (+1,0), 1 = (0,+1), 2 = (+1,+1), 3 = (+1,-1).
  - run = 1 + matching cells in +dir + matching cells in -dir. Each side stops at the board edge or the first non-matching cell, maximum K-1 cells per side.
  - run >= K sets an internal win flag.
  - After dir 3 (edge E4), go to DONE.
- DONE, edge E5:
  - win: winner=player, stop_game=1, go to OVER.
  - else count==N*N: draw=1, stop_game=1, go to OVER.
  - else: player toggles, go to IDLE.
  - busy=0 from E5.
- Latency: move at E0 -> result or player toggle registered at E5. The next move is accepted at E6 at the earliest.
- enable=1 while busy or in OVER: move_err pulse, no state change.
- OVER holds the board, winner, draw and stop_game until reset or restart.
- A win on the final cell reports win (draw stays 0).
- Scan reads the board with the new cell already written.
- No counter or coordinate wraps: count saturates at N*N because a full board forces OVER.

Test Plan:
1. N=3,K=3. Moves, each waiting for busy=0: (0,0),(1,0),(0,1),(1,1),(0,2). -> Each move gives move_ok. After the last move, board=18'h01249, winner=0, stop_game=1, draw=0; busy is high for exactly 5 cycles per move.
2. N=3. Moves P0(0,0),P1(1,0),P0(2,0),P1(1,1),P0(1,2),P1(2,1),P0(0,1),P1(0,2),P0(2,2). -> draw=1, stop_game=1; player does not toggle after the final move.
3. P0 at (0,0), then P1 strobes (0,0); separately strobe (3,1). -> Each gives a move_err pulse; board unchanged; player stays 1.
4. Strobe enable on the cycle after move_ok, and again after stop_game is set. -> move_err each time; board unchanged. Then restart=1 -> board=0, player=0, stop_game=0.
5. N=5,K=4. P0 builds (1,1),(2,2),(3,3),(4,4) while P1 plays row 0. -> winner=0 at E5 of the 4th P0 move. Repeat with K=5 -> no win.
6. Assert reset asynchronously during CHECK dir 2. -> All outputs zero immediately, before the next clock edge; a subsequent move at (0,0) is accepted normally.
